// File: rtl/pinky_pkg.sv
// Shared types and defaults for the PinKY issue scoreboard.
//   MAXLAT_DEFAULT / NREG_DEFAULT : default pipe depth and register count
//   reg_idx_t                     : 4-bit architectural register index
//   slot_t                        : one in-flight writeback entry
//   PC_REG                        : r15, writes to it are jumps
package pinky_pkg;

  localparam int unsigned MAXLAT_DEFAULT = 4;
  localparam int unsigned NREG_DEFAULT   = 16;
  localparam int unsigned REG_W          = 4;
  localparam int unsigned LAT_W          = 3;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     v;
    reg_idx_t dest;
    logic     wr;
    logic     setz;
    logic     mem;
  } slot_t;

  localparam reg_idx_t PC_REG = 4'd15;

endpackage

// File: rtl/pinky_wb_pipe.sv
// Writeback schedule: a MAXLAT-deep shift register of slot entries.
// Slot k holds the result due k cycles from now; slot 0 is the current
// writeback. An insert with latency L lands in post-shift slot L-1.
//   clk, reset            : clock, synchronous active-high reset
//   ins_en/ins_lat/ins_entry : insert request
//   occ                   : per-slot valid bits (pre-shift view)
//   busy/zpend/mpend      : pending register writes, Z writers, memory ops
//   wb_valid/wb_dest/wb_setz : slot 0 presented as the write-port command
module pinky_wb_pipe
  import pinky_pkg::*;
#(
  parameter int unsigned MAXLAT = MAXLAT_DEFAULT,
  parameter int unsigned NREG   = NREG_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ins_en,
  input  logic [LAT_W-1:0]  ins_lat,
  input  slot_t             ins_entry,
  output logic [MAXLAT-1:0] occ,
  output logic [NREG-1:0]   busy,
  output logic              zpend,
  output logic              mpend,
  output logic              wb_valid,
  output reg_idx_t          wb_dest,
  output logic              wb_setz
);

  slot_t slot_q [MAXLAT];
  slot_t slot_d [MAXLAT];

  // Shift toward slot 0 with empty fill at the top, then apply the insert.
  always_comb begin
    for (int unsigned k = 0; k < MAXLAT; k++) begin
      slot_d[k] = '0;
    end
    for (int unsigned k = 0; k + 1 < MAXLAT; k++) begin
      slot_d[k] = slot_q[k+1];
    end
    for (int unsigned k = 0; k < MAXLAT; k++) begin
      if (ins_en && (32'(ins_lat) == k + 1)) begin
        slot_d[k] = ins_entry;
      end
    end
  end

  // Slot storage; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < MAXLAT; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < MAXLAT; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Occupancy summaries derived purely from slot contents.
  always_comb begin
    occ   = '0;
    busy  = '0;
    zpend = 1'b0;
    mpend = 1'b0;
    for (int unsigned k = 0; k < MAXLAT; k++) begin
      occ[k] = slot_q[k].v;
      if (slot_q[k].v && slot_q[k].wr) begin
        busy[slot_q[k].dest] = 1'b1;
      end
      if (slot_q[k].v && slot_q[k].setz) begin
        zpend = 1'b1;
      end
      if (slot_q[k].v && slot_q[k].mem) begin
        mpend = 1'b1;
      end
    end
  end

  // A store occupies slot 0 but never drives the register write port.
  assign wb_valid = slot_q[0].v && slot_q[0].wr;
  assign wb_dest  = slot_q[0].dest;
  assign wb_setz  = slot_q[0].v && slot_q[0].setz;

endmodule

// File: rtl/pinky_scoreboard.sv
// Issue interlock for the PinKY pipeline. Decides each cycle whether the
// decoded instruction may issue, records it in the writeback schedule and
// presents slot 0 as the register-file write command.
//   clk, reset        : clock, synchronous active-high reset
//   iss_*             : decoded instruction fields; iss_ready is combinational
//   wb_valid/dest/setz: writeback for this cycle
//   busy              : per-register pending-write vector
//   jump_pending      : write to r15 in flight
//   err               : sticky, an illegal latency was presented
module pinky_scoreboard
  import pinky_pkg::*;
#(
  parameter int unsigned MAXLAT = MAXLAT_DEFAULT,
  parameter int unsigned NREG   = NREG_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iss_valid,
  input  logic [3:0]      iss_dest,
  input  logic [3:0]      iss_src,
  input  logic            iss_src_en,
  input  logic            iss_wr,
  input  logic            iss_setz,
  input  logic            iss_usez,
  input  logic            iss_mem,
  input  logic [2:0]      iss_lat,
  output logic            iss_ready,
  output logic            wb_valid,
  output logic [3:0]      wb_dest,
  output logic            wb_setz,
  output logic [NREG-1:0] busy,
  output logic            jump_pending,
  output logic            err
);

  logic [MAXLAT-1:0] occ;
  logic              zpend;
  logic              mpend;
  logic              lat_ok;
  logic              collide;
  logic              hazard;
  logic              issue;
  slot_t             entry;

  assign jump_pending = busy[PC_REG];

  // Hazard checks; op1 is always the dest register, so it covers RAW and WAW.
  always_comb begin
    lat_ok  = (iss_lat != '0) && (32'(iss_lat) <= MAXLAT);
    collide = 1'b0;
    // Current slot[L] shifts into the insert position; L == MAXLAT never collides.
    for (int unsigned k = 0; k < MAXLAT; k++) begin
      if ((32'(iss_lat) == k) && occ[k]) begin
        collide = 1'b1;
      end
    end
    hazard = busy[iss_dest]
           | (iss_src_en && busy[iss_src])
           | ((iss_usez || iss_setz) && zpend)
           | (iss_mem && mpend)
           | jump_pending
           | collide;
    iss_ready = !reset && !err && lat_ok && !hazard;
    issue     = iss_valid && iss_ready;
    entry     = '{v: 1'b1, dest: iss_dest, wr: iss_wr, setz: iss_setz, mem: iss_mem};
  end

  // Sticky illegal-latency flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (iss_valid && !lat_ok) begin
      err <= 1'b1;
    end
  end

  pinky_wb_pipe #(
    .MAXLAT (MAXLAT),
    .NREG   (NREG)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .ins_en    (issue),
    .ins_lat   (iss_lat),
    .ins_entry (entry),
    .occ       (occ),
    .busy      (busy),
    .zpend     (zpend),
    .mpend     (mpend),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest),
    .wb_setz   (wb_setz)
  );

endmodule

// File: tb/tb_pinky_scoreboard.sv
module tb_pinky_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iss_valid = 1'b0;
  logic [3:0]  iss_dest = '0;
  logic [3:0]  iss_src = '0;
  logic        iss_src_en = 1'b0;
  logic        iss_wr = 1'b0;
  logic        iss_setz = 1'b0;
  logic        iss_usez = 1'b0;
  logic        iss_mem = 1'b0;
  logic [2:0]  iss_lat = 3'd1;
  logic        iss_ready;
  logic        wb_valid;
  logic [3:0]  wb_dest;
  logic        wb_setz;
  logic [15:0] busy;
  logic        jump_pending;
  logic        err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  pinky_scoreboard #(.MAXLAT(4), .NREG(16)) dut (
    .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_dest(iss_dest),
    .iss_src(iss_src), .iss_src_en(iss_src_en), .iss_wr(iss_wr),
    .iss_setz(iss_setz), .iss_usez(iss_usez), .iss_mem(iss_mem),
    .iss_lat(iss_lat), .iss_ready(iss_ready), .wb_valid(wb_valid),
    .wb_dest(wb_dest), .wb_setz(wb_setz), .busy(busy),
    .jump_pending(jump_pending), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight ops kept by the absolute cycle their result is due.
  typedef struct {
    int       wb;
    bit [3:0] dest;
    bit       wr;
    bit       setz;
    bit       mem;
  } op_t;

  op_t ops[$];
  int  cyc   = 0;
  bit  m_err = 0;

  function automatic bit legal_lat();
    return (iss_lat >= 3'd1) && (iss_lat <= 3'd4);
  endfunction

  function automatic bit m_ready();
    bit blk = 0;
    if (reset || m_err || !legal_lat()) return 0;
    foreach (ops[i]) begin
      if (ops[i].wr && (ops[i].dest == iss_dest)) blk = 1;
      if (ops[i].wr && iss_src_en && (ops[i].dest == iss_src)) blk = 1;
      if (ops[i].setz && (iss_setz || iss_usez)) blk = 1;
      if (ops[i].mem && iss_mem) blk = 1;
      if (ops[i].wr && (ops[i].dest == 4'd15)) blk = 1;
      if (ops[i].wb == cyc + int'(iss_lat)) blk = 1;
    end
    return !blk;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, exp);
    end
  endtask

  // Model update on the active edge.
  always @(posedge clk) begin
    if (reset) begin
      ops.delete();
      m_err = 0;
    end else if (iss_valid && !legal_lat()) begin
      m_err = 1;
    end else if (iss_valid && m_ready()) begin
      ops.push_back('{wb: cyc + int'(iss_lat), dest: iss_dest, wr: iss_wr,
                      setz: iss_setz, mem: iss_mem});
    end
    cyc++;
    for (int i = ops.size() - 1; i >= 0; i--) begin
      if (ops[i].wb < cyc) ops.delete(i);
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    bit          ev;
    bit          es;
    bit [3:0]    ed;
    bit [15:0]   eb;
    #2;
    if (chk_en) begin
      ev = 0; es = 0; ed = 0; eb = 0;
      foreach (ops[i]) begin
        if (ops[i].wr) eb[ops[i].dest] = 1;
        if (ops[i].wb == cyc) begin
          if (ops[i].wr) begin ev = 1; ed = ops[i].dest; end
          if (ops[i].setz) es = 1;
        end
      end
      chk("iss_ready", 32'(iss_ready), 32'(m_ready()));
      chk("wb_valid", 32'(wb_valid), 32'(ev));
      chk("wb_setz", 32'(wb_setz), 32'(es));
      chk("busy", 32'(busy), 32'(eb));
      chk("jump_pending", 32'(jump_pending), 32'(eb[15]));
      chk("err", 32'(err), 32'(m_err));
      if (ev) chk("wb_dest", 32'(wb_dest), 32'(ed));
    end
  end

  task automatic drive(input bit rst, input bit v, input int d, input int s,
                       input bit sen, input bit wr, input bit sz, input bit uz,
                       input bit mem, input int lat);
    @(negedge clk);
    reset = rst; iss_valid = v; iss_dest = 4'(d); iss_src = 4'(s);
    iss_src_en = sen; iss_wr = wr; iss_setz = sz; iss_usez = uz;
    iss_mem = mem; iss_lat = 3'(lat);
    #3;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic op(input int d, input int s, input bit sen, input bit wr,
                    input bit sz, input bit uz, input bit mem, input int lat);
    drive(0, 1, d, s, sen, wr, sz, uz, mem, lat);
  endtask

  initial begin
    // Reset and single add
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_ready", 32'(iss_ready), 32'd0);
    chk_en = 1;
    op(1, 0, 0, 1, 0, 0, 0, 1);
    chk("add_ready", 32'(iss_ready), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_dest", 32'(wb_dest), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle();
    chk("add_wb_valid", 32'(wb_valid), 32'd1);
    chk("add_wb_dest", 32'(wb_dest), 32'd1);
    chk("add_busy", 32'(busy), 32'h0002);
    idle();
    chk("add_busy_clr", 32'(busy), 32'd0);

    // RAW on src
    op(2, 0, 0, 1, 0, 0, 0, 4);
    for (int i = 1; i <= 4; i++) begin
      op(3, 2, 1, 1, 0, 0, 0, 1);
      chk("raw_stall", 32'(iss_ready), 32'd0);
    end
    chk("raw_fpu_wb", 32'(wb_dest), 32'd2);
    op(3, 2, 1, 1, 0, 0, 0, 1);
    chk("raw_issue", 32'(iss_ready), 32'd1);
    idle();
    chk("raw_add_wb", 32'(wb_valid && wb_dest == 4'd3), 32'd1);

    // Write-port collision
    op(4, 0, 0, 1, 0, 0, 0, 3);
    op(5, 0, 0, 1, 0, 0, 0, 2);
    chk("col_stall", 32'(iss_ready), 32'd0);
    op(5, 0, 0, 1, 0, 0, 0, 2);
    chk("col_issue", 32'(iss_ready), 32'd1);
    idle();
    chk("col_wb_r4", 32'(wb_dest), 32'd4);
    idle();
    chk("col_wb_r5", 32'(wb_dest), 32'd5);
    idle();

    // Z ordering, then a jump
    op(6, 0, 0, 1, 1, 0, 0, 2);
    op(7, 0, 0, 1, 0, 1, 0, 1);
    chk("z_stall1", 32'(iss_ready), 32'd0);
    op(7, 0, 0, 1, 0, 1, 0, 1);
    chk("z_stall2", 32'(iss_ready), 32'd0);
    chk("z_wb_setz", 32'(wb_setz), 32'd1);
    op(7, 0, 0, 1, 0, 1, 0, 1);
    chk("z_issue", 32'(iss_ready), 32'd1);
    idle();
    op(15, 0, 0, 1, 0, 0, 0, 1);
    chk("jmp_issue", 32'(iss_ready), 32'd1);
    op(1, 0, 0, 1, 0, 0, 0, 1);
    chk("jmp_pending", 32'(jump_pending), 32'd1);
    chk("jmp_block", 32'(iss_ready), 32'd0);
    op(1, 0, 0, 1, 0, 0, 0, 1);
    chk("jmp_release", 32'(iss_ready), 32'd1);
    idle();

    // Memory serialization, then illegal latency
    op(8, 0, 0, 0, 0, 0, 1, 2);
    chk("str_issue", 32'(iss_ready), 32'd1);
    op(9, 0, 0, 1, 0, 0, 1, 2);
    chk("ldr_stall1", 32'(iss_ready), 32'd0);
    op(9, 0, 0, 1, 0, 0, 1, 2);
    chk("ldr_stall2", 32'(iss_ready), 32'd0);
    chk("str_no_wb", 32'(wb_valid), 32'd0);
    op(9, 0, 0, 1, 0, 0, 1, 2);
    chk("ldr_issue", 32'(iss_ready), 32'd1);
    idle();
    idle();
    chk("ldr_wb", 32'(wb_dest), 32'd9);
    op(1, 0, 0, 1, 0, 0, 0, 0);
    chk("lat0_ready", 32'(iss_ready), 32'd0);
    op(1, 0, 0, 1, 0, 0, 0, 1);
    chk("err_set", 32'(err), 32'd1);
    chk("err_block", 32'(iss_ready), 32'd0);
    op(1, 0, 0, 1, 0, 0, 0, 1);
    chk("err_hold", 32'(iss_ready), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("err_clr", 32'(err), 32'd0);

    // Reset mid-flight
    op(1, 0, 0, 1, 0, 0, 0, 4);
    op(2, 0, 0, 1, 0, 0, 0, 2);
    op(3, 0, 0, 1, 0, 0, 0, 4);
    chk("flight_issue", 32'(iss_ready), 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("flight_wb", 32'(wb_valid), 32'd0);
    chk("flight_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("flight_stale", 32'(wb_valid), 32'd0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit rst;
      int lat;
      rst = ($urandom_range(0, 99) == 0) || (m_err && $urandom_range(0, 7) == 0);
      lat = ($urandom_range(0, 63) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 7)))
                                         : int'($urandom_range(1, 4));
      drive(rst, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 31) == 0) ? 15 : int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, lat);
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
